// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU load/store path and a
// debug/loader port. Grants are combinational; completions are registered.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [31:0]       dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_lock_i,
  output logic              cpu_gnt_o,
  output logic              dbg_gnt_o,
  output logic              cpu_valid_o,
  output logic              dbg_valid_o,
  output logic              cpu_err_o,
  output logic              dbg_err_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] DBG_LOCK   = 1'b1;
  localparam logic       OWNER_CPU  = 1'b0;
  localparam logic       OWNER_DBG  = 1'b1;
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [0:0]        state;
  logic              last_owner;
  logic [3:0]        wait_cnt;

  logic              cpu_wins_tie;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_err;
  logic              mem_en;

  // In DBG_LOCK the CPU only wins a tie once it has been starved MAX_WAIT cycles.
  always_comb begin
    if (state == DBG_LOCK) begin
      cpu_wins_tie = (wait_cnt == WAIT_LIMIT);
    end else begin
      cpu_wins_tie = (last_owner == OWNER_DBG);
    end
    cpu_gnt = cpu_req_i && (!dbg_req_i || cpu_wins_tie);
    dbg_gnt = dbg_req_i && !cpu_gnt;
    any_gnt = cpu_gnt || dbg_gnt;
  end

  always_comb begin
    if (cpu_gnt) begin
      sel_we    = cpu_we_i;
      sel_addr  = cpu_addr_i;
      sel_wdata = cpu_wdata_i;
    end else begin
      sel_we    = dbg_we_i;
      sel_addr  = dbg_addr_i;
      sel_wdata = dbg_wdata_i;
    end
  end

  always_comb begin
    addr_err = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (ADDR_W + 2)) != '0);
    mem_en   = any_gnt && !addr_err;
  end

  // Faulting accesses are still granted but never reach the memory.
  always_comb begin
    mem_en_o    = mem_en;
    mem_we_o    = mem_en && sel_we;
    mem_addr_o  = mem_en ? sel_addr[ADDR_W+1:2] : '0;
    mem_wdata_o = mem_en ? sel_wdata : '0;
  end

  assign cpu_gnt_o = cpu_gnt;
  assign dbg_gnt_o = dbg_gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (dbg_gnt && dbg_lock_i) begin
            state <= DBG_LOCK;
          end
        end
        DBG_LOCK: begin
          if (!dbg_req_i || (dbg_gnt && !dbg_lock_i)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_owner <= OWNER_DBG;
    end else if (cpu_gnt) begin
      last_owner <= OWNER_CPU;
    end else if (dbg_gnt) begin
      last_owner <= OWNER_DBG;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (cpu_req_i && !cpu_gnt) begin
      if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cpu_valid_o <= 1'b0;
      cpu_err_o   <= 1'b0;
      cpu_rdata_o <= '0;
    end else begin
      cpu_valid_o <= cpu_gnt;
      cpu_err_o   <= cpu_gnt && addr_err;
      if (cpu_gnt && !addr_err && !cpu_we_i) begin
        cpu_rdata_o <= mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbg_valid_o <= 1'b0;
      dbg_err_o   <= 1'b0;
      dbg_rdata_o <= '0;
    end else begin
      dbg_valid_o <= dbg_gnt;
      dbg_err_o   <= dbg_gnt && addr_err;
      if (dbg_gnt && !addr_err && !dbg_we_i) begin
        dbg_rdata_o <= mem_rdata_i;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the CPU load/store path and a debug/loader port. Each cycle it grants at most one requester and drives the memory port combinationally, then returns registered read data and a completion pulse one cycle later. Ties are resolved round-robin. The debug port may lock the memory for a burst, bounded by a CPU starvation limit. A CPU that is not granted must stall its PC.

## Interface
Parameters:
- DATA_W, 32, data width
- ADDR_W, 5, word-address width (memory depth 2^ADDR_W words)
- MAX_WAIT, 4, consecutive denied CPU cycles before a forced CPU grant (1..15)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cpu_req_i / dbg_req_i  in  1  access request
- cpu_we_i / dbg_we_i  in  1  1 = write, 0 = read
- cpu_addr_i / dbg_addr_i  in  32  byte address
- cpu_wdata_i / dbg_wdata_i  in  DATA_W  write data
- dbg_lock_i  in  1  hold ownership after this debug access
- cpu_gnt_o / dbg_gnt_o  out  1  access accepted this cycle (combinational)
- cpu_valid_o / dbg_valid_o  out  1  completion pulse, one cycle after grant
- cpu_err_o / dbg_err_o  out  1  access was misaligned or out of range; qualified by valid
- cpu_rdata_o / dbg_rdata_o  out  DATA_W  registered read data
- mem_en_o  out  1  memory access enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  word address
- mem_wdata_o  out  DATA_W  write data to memory
- mem_rdata_i  in  DATA_W  combinational read data from memory

## Operation
- States: IDLE, DBG_LOCK. Registers: last_owner (0 = CPU, 1 = DBG), wait_cnt[3:0].
- Grant decision, combinational, at most one grant per cycle:
  - No requests: no grant; mem_en_o = 0.
  - Exactly one request: that requester is granted.
  - Both request in DBG_LOCK: DBG is granted, unless wait_cnt == MAX_WAIT, in which case CPU is granted.
  - Both request in IDLE: the requester that is not last_owner is granted.
- last_owner updates to the granted requester at each clock edge with a grant.
- Lock rules:
  - IDLE -> DBG_LOCK on a DBG grant with dbg_lock_i = 1.
  - DBG_LOCK -> IDLE on a DBG grant with dbg_lock_i = 0, or on any cycle with dbg_req_i = 0.
  - A forced CPU grant does not leave DBG_LOCK.
- wait_cnt:
  - Increments while cpu_req_i = 1 and cpu_gnt_o = 0, saturating at MAX_WAIT.
  - Clears on cpu_gnt_o = 1 or cpu_req_i = 0.
- Memory port follows the granted requester: mem_addr_o = addr[ADDR_W+1:2]; mem_we_o = we & mem_en_o.
- Error: addr[1:0] != 0, or addr[31:ADDR_W+2] != 0.
  - The access is still granted, but mem_en_o = 0 and no write occurs.
  - err_o is asserted together with that access's valid_o.
- Completion:
  - valid_o pulses for exactly one cycle, on the cycle after the grant.
  - On a non-error read, rdata_o captures mem_rdata_i at the grant edge.
  - Otherwise rdata_o holds its previous value.
- When mem_en_o = 0, mem_addr_o, mem_wdata_o and mem_we_o are 0.

## Timing
- Reset (asynchronous): state IDLE, last_owner = DBG (CPU wins the first tie), wait_cnt = 0, all valid/err/rdata outputs 0. Grant and mem outputs are then 0 because the requests gate them.
- Grant is same-cycle combinational from the requests. Writes commit at the grant edge. Read data latency is 1 cycle.
- Back-to-back grants to the same requester are legal: one access per cycle, valid_o asserted on consecutive cycles.
- Simultaneous requests in IDLE alternate every cycle: C, D, C, D…
- Reset mid-access: a pending valid_o is dropped and state returns to IDLE immediately; no retry.
- A requester must hold req, we, addr and wdata stable until granted.

## Test plan
- Reset then CPU read of addr 0x8 with mem word 2 = 7: cpu_gnt_o=1 same cycle, mem_addr_o=2; next cycle cpu_valid_o=1, cpu_rdata_o=7.
- Both requesters writing continuously from IDLE after reset: grants go CPU, DBG, CPU, DBG; memory receives the writes in that order.
- DBG locked burst (dbg_lock_i=1) while CPU requests, MAX_WAIT=4: DBG granted 4 cycles, CPU forced on the 5th, DBG resumes on the 6th, state stays DBG_LOCK.
- CPU write to 0x6 (misaligned), then to 0x80 (ADDR_W=5, out of range): granted, mem_en_o=0, cpu_valid_o=1 with cpu_err_o=1, memory unchanged.
- DBG drops dbg_req_i while in DBG_LOCK: returns to IDLE; the next tie goes to CPU.
- rst_i asserted the cycle after a CPU read grant: cpu_valid_o stays 0, state IDLE, last_owner = DBG.
